ex_stage: RTL and testbench

- RV32I execute stage; consumes the decoded operands latched by the ID/EX register and contains the EX/MEM output latch.
- Computes ALU results, branch/jump redirects, memory addresses and store data.
- SLL/SRL/SRA run on an area-saving 1-bit-per-cycle serial shifter. The stage raises a stall request while that shifter is busy.
- Provides the EX forwarding path back to the ID/EX register.

---
 rtl/ex_stage.sv | 120 ++++++++++++
 tb/tb_ex_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with a 1-bit-per-cycle serial shifter and EX/MEM output latch.
module ex_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              mem_hold,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   r1_data,
  input  logic [XLEN-1:0]   r2_data,
  input  logic [4:0]        rd_addr,
  input  logic [XLEN-1:0]   imm,
  input  logic [6:0]        ins_type,
  input  logic [2:0]        ins_details,
  input  logic              ins_diff,
  output logic              stall_req,
  output logic              jump_enable,
  output logic [XLEN-1:0]   jump_target,
  output logic              forward_ex_enable,
  output logic [4:0]        forward_ex_addr,
  output logic [XLEN-1:0]   forward_ex_data,
  output logic [4:0]        out_rd_addr,
  output logic              out_wb_enable,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [6:0]        out_ins_type,
  output logic [2:0]        out_ins_details
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_ALOPI = 7'b0010011, OP_ALOP = 7'b0110011;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [SHAMT_W-1:0] cnt, cnt_nx, shamt;
  logic [XLEN-1:0] acc, acc_nx, opb, sum, pc_imm, add_sub, alu, idle_res, result;
  logic [1:0] kind, kind_nx, kind_i;
  logic alop_q, alop_nx, is_alop, is_alu, is_shift, long_shift, taken, writes, wr, valid, en, slt, sltu;
  logic [6:0] o_type;
  logic [2:0] o_det;
  // kind: 0 = SLL, 1 = SRL, 2 = SRA
  function automatic logic [XLEN-1:0] sh1(input logic [XLEN-1:0] v, input logic [1:0] k);
    return k == 2'd0 ? v << 1 : {k == 2'd2 & v[XLEN-1], v[XLEN-1:1]};
  endfunction
  always_comb begin
    en         = rdy_in & ~mem_hold;
    is_alop    = ins_type == OP_ALOP;
    is_alu     = is_alop | ins_type == OP_ALOPI;
    opb        = is_alop ? r2_data : imm;
    sum        = r1_data + imm;
    pc_imm     = pc + imm;
    shamt      = opb[SHAMT_W-1:0];
    is_shift   = is_alu & ins_details[1:0] == 2'b01;
    kind_i     = ins_details[2] ? (ins_diff ? 2'd2 : 2'd1) : 2'd0;
    long_shift = is_shift & shamt > SHAMT_W'(1);
    slt        = $signed(r1_data) < $signed(opb);
    sltu       = r1_data < opb;
    add_sub    = (is_alop & ins_diff) ? r1_data - opb : r1_data + opb;
    alu = ins_details == 3'b000 ? add_sub :
          ins_details == 3'b010 ? {{(XLEN-1){1'b0}}, slt} :
          ins_details == 3'b011 ? {{(XLEN-1){1'b0}}, sltu} :
          ins_details == 3'b100 ? r1_data ^ opb :
          ins_details == 3'b110 ? r1_data | opb :
          ins_details == 3'b111 ? r1_data & opb :
          shamt == '0 ? r1_data : sh1(r1_data, kind_i);
    taken = ins_details[2:1] == 2'b00 ? (r1_data == r2_data) ^ ins_details[0] :
            ins_details[2:1] == 2'b10 ? ($signed(r1_data) < $signed(r2_data)) ^ ins_details[0] :
            ins_details[2:1] == 2'b11 ? (r1_data < r2_data) ^ ins_details[0] : 1'b0;
    writes = ins_type == OP_LUI | ins_type == OP_AUIPC | ins_type == OP_JAL | ins_type == OP_JALR | is_alu;
    idle_res = ins_type == OP_LUI ? imm :
               ins_type == OP_AUIPC ? pc_imm :
               (ins_type == OP_JAL | ins_type == OP_JALR) ? pc + XLEN'(4) :
               is_alu ? alu : sum;
    result = state == SHIFT ? sh1(acc, kind) : idle_res;
    wr     = state == SHIFT | writes;
    valid  = state == SHIFT ? cnt == SHAMT_W'(1) : ~long_shift;
    stall_req         = state == SHIFT ? cnt != SHAMT_W'(1) : long_shift;
    jump_enable       = state == IDLE & (ins_type == OP_JAL | ins_type == OP_JALR | (ins_type == OP_BRANCH & taken));
    jump_target       = jump_enable ? (ins_type == OP_JALR ? sum & ~XLEN'(1) : pc_imm) : '0;
    forward_ex_enable = valid & wr & rd_addr != 5'd0;
    forward_ex_addr   = forward_ex_enable ? rd_addr : 5'd0;
    forward_ex_data   = forward_ex_enable ? result : '0;
    state_nx = state == SHIFT ? (cnt == SHAMT_W'(1) ? IDLE : SHIFT) : (long_shift ? SHIFT : IDLE);
    cnt_nx   = state == SHIFT ? cnt - SHAMT_W'(1) : (long_shift ? shamt - SHAMT_W'(1) : cnt);
    acc_nx   = state == SHIFT ? sh1(acc, kind) : (long_shift ? sh1(r1_data, kind_i) : acc);
    kind_nx  = state == IDLE & long_shift ? kind_i : kind;
    alop_nx  = state == IDLE & long_shift ? is_alop : alop_q;
    // a finishing shift reports its own opcode, latched at accept time
    o_type = state == SHIFT ? (alop_q ? OP_ALOP : OP_ALOPI) : ins_type;
    o_det  = state == SHIFT ? {kind != 2'd0, 2'b01} : ins_details;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      cnt             <= '0;
      acc             <= '0;
      kind            <= 2'd0;
      alop_q          <= 1'b0;
      out_rd_addr     <= 5'd0;
      out_wb_enable   <= 1'b0;
      out_result      <= '0;
      out_store_data  <= '0;
      out_ins_type    <= OP_ALOPI;
      out_ins_details <= 3'b000;
    end else if (en) begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      acc             <= acc_nx;
      kind            <= kind_nx;
      alop_q          <= alop_nx;
      out_rd_addr     <= valid ? rd_addr : 5'd0;
      out_wb_enable   <= valid & (wr | ins_type == OP_LOAD) & rd_addr != 5'd0;
      out_result      <= valid ? result : '0;
      out_store_data  <= valid ? r2_data : '0;
      out_ins_type    <= valid ? o_type : OP_ALOPI;
      out_ins_details <= valid ? o_det : 3'b000;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage; writeback results checked by a queue-based monitor.
module tb_ex_stage;
  localparam logic [6:0] LUI = 7'b0110111, JALR = 7'b1100111, BR = 7'b1100011,
                         ST = 7'b0100011, ALOPI = 7'b0010011, ALOP = 7'b0110011;
  typedef struct { logic [4:0] rd; logic [31:0] res; } exp_t;
  logic clk = 0, rst = 1, rdy = 1, hold = 0;
  logic [31:0] pc, r1, r2, imm;
  logic [4:0] rd;
  logic [6:0] op;
  logic [2:0] f3;
  logic diff;
  logic stall_req, jump_enable, forward_ex_enable, out_wb_enable;
  logic [31:0] jump_target, forward_ex_data, out_result, out_store_data;
  logic [4:0] forward_ex_addr, out_rd_addr;
  logic [6:0] out_ins_type;
  logic [2:0] out_ins_details;
  int tests = 0, fails = 0;
  exp_t q[$];

  ex_stage dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_hold(hold), .pc(pc),
    .r1_data(r1), .r2_data(r2), .rd_addr(rd), .imm(imm), .ins_type(op),
    .ins_details(f3), .ins_diff(diff), .stall_req(stall_req), .jump_enable(jump_enable),
    .jump_target(jump_target), .forward_ex_enable(forward_ex_enable),
    .forward_ex_addr(forward_ex_addr), .forward_ex_data(forward_ex_data),
    .out_rd_addr(out_rd_addr), .out_wb_enable(out_wb_enable), .out_result(out_result),
    .out_store_data(out_store_data), .out_ins_type(out_ins_type), .out_ins_details(out_ins_details)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic d, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] i, input logic [31:0] p);
    op = o; f3 = f; diff = d; rd = r; r1 = a; r2 = b; imm = i; pc = p;
  endtask

  task automatic nop();
    drive(ALOPI, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] r, input logic [31:0] v);
    exp_t e;
    e.rd = r;
    e.res = v;
    q.push_back(e);
  endtask

  // Runs a shift already on the inputs for n cycles; stall must be high on all but the last.
  task automatic shift_run(input string name, input int n);
    int stalls = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (stall_req) stalls++;
      if (i == n - 1) chk({name, "_fwd_last"}, {31'b0, forward_ex_enable}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk({name, "_stalls"}, stalls, n - 1);
    nop();
  endtask

  // Monitor: pops an expectation whenever the stage presents a forwardable result that will latch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rdy && !hold && forward_ex_enable) begin
        if (q.size() == 0) begin
          chk("unexpected_result", {27'b0, forward_ex_addr}, 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          chk("fwd_addr", {27'b0, forward_ex_addr}, {27'b0, e.rd});
          chk("fwd_data", forward_ex_data, e.res);
          @(posedge clk);
          #1;
          chk("out_rd", {27'b0, out_rd_addr}, {27'b0, e.rd});
          chk("out_result", out_result, e.res);
          chk("out_wb", {31'b0, out_wb_enable}, 32'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nop();
    step();
    step();
    chk("rst_type", {25'b0, out_ins_type}, {25'b0, ALOPI});
    chk("rst_result", out_result, 32'h0);
    chk("rst_wb", {31'b0, out_wb_enable}, 32'd0);
    chk("rst_comb", {29'b0, stall_req, jump_enable, forward_ex_enable}, 32'd0);
    rst = 0;
    step();
    // ADDI x5,x0,-1
    drive(ALOPI, 3'b000, 1'b0, 5'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0);
    expect_wb(5'd5, 32'hFFFFFFFF);
    #1;
    chk("addi_fwd_en", {31'b0, forward_ex_enable}, 32'd1);
    step();
    // SUB x10 = 5 - 7
    drive(ALOP, 3'b000, 1'b1, 5'd10, 32'd5, 32'd7, 32'h0, 32'h0);
    expect_wb(5'd10, 32'hFFFFFFFE);
    step();
    // LUI x11
    drive(LUI, 3'b000, 1'b0, 5'd11, 32'h0, 32'h0, 32'h12345000, 32'h0);
    expect_wb(5'd11, 32'h12345000);
    step();
    // SRAI by 4, 0, 31
    drive(ALOPI, 3'b101, 1'b1, 5'd6, 32'h80000000, 32'h0, 32'h404, 32'h0);
    expect_wb(5'd6, 32'hF8000000);
    shift_run("sra4", 4);
    drive(ALOPI, 3'b101, 1'b1, 5'd6, 32'h80000000, 32'h0, 32'h400, 32'h0);
    expect_wb(5'd6, 32'h80000000);
    shift_run("sra0", 1);
    drive(ALOPI, 3'b101, 1'b1, 5'd6, 32'h80000000, 32'h0, 32'h41F, 32'h0);
    expect_wb(5'd6, 32'hFFFFFFFF);
    shift_run("sra31", 31);
    // SRL by 1 (single-cycle) fills with zero
    drive(ALOP, 3'b101, 1'b0, 5'd12, 32'h80000001, 32'd1, 32'h0, 32'h0);
    expect_wb(5'd12, 32'h40000000);
    shift_run("srl1", 1);
    // BLT / BLTU with -1 vs 1
    drive(BR, 3'b100, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h100);
    #1;
    chk("blt_jump", {31'b0, jump_enable}, 32'd1);
    chk("blt_target", jump_target, 32'h140);
    chk("blt_fwd", {31'b0, forward_ex_enable}, 32'd0);
    step();
    drive(BR, 3'b110, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h100);
    #1;
    chk("bltu_jump", {31'b0, jump_enable}, 32'd0);
    step();
    // JALR
    drive(JALR, 3'b000, 1'b0, 5'd1, 32'h1003, 32'h0, 32'd4, 32'h200);
    expect_wb(5'd1, 32'h204);
    #1;
    chk("jalr_jump", {31'b0, jump_enable}, 32'd1);
    chk("jalr_target", jump_target, 32'h1006);
    step();
    // SW: address and store data latched, no writeback
    drive(ST, 3'b010, 1'b0, 5'd3, 32'h100, 32'hDEAD, 32'd8, 32'h0);
    step();
    chk("st_addr", out_result, 32'h108);
    chk("st_data", out_store_data, 32'hDEAD);
    chk("st_wb", {31'b0, out_wb_enable}, 32'd0);
    nop();
    step();
    // SLL by 5 with a 2-cycle mem_hold mid-shift
    begin
      int stalls = 0;
      drive(ALOP, 3'b001, 1'b0, 5'd7, 32'h123, 32'd5, 32'h0, 32'h0);
      expect_wb(5'd7, 32'h2460);
      for (int i = 0; i < 7; i++) begin
        hold = (i == 2 || i == 3);
        #1;
        if (stall_req) stalls++;
        if (i == 6) chk("sll_hold_fwd_last", {31'b0, forward_ex_enable}, 32'd1);
        @(posedge clk);
        #1;
      end
      hold = 0;
      chk("sll_hold_stalls", stalls, 6);
      nop();
    end
    step();
    // Reset in cycle 4 of SLL by 10
    drive(ALOPI, 3'b001, 1'b0, 5'd8, 32'h1, 32'h0, 32'd10, 32'h0);
    step();
    step();
    step();
    nop();
    rst = 1;
    #1;
    chk("mid_rst_stall", {31'b0, stall_req}, 32'd0);
    chk("mid_rst_rd", {27'b0, out_rd_addr}, 32'd0);
    chk("mid_rst_type", {25'b0, out_ins_type}, {25'b0, ALOPI});
    step();
    rst = 0;
    drive(ALOPI, 3'b000, 1'b0, 5'd9, 32'h0, 32'h0, 32'd5, 32'h0);
    expect_wb(5'd9, 32'd5);
    #1;
    chk("post_rst_stall", {31'b0, stall_req}, 32'd0);
    step();
    nop();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
